// File: rtl/mul_pkg.sv
// Shared types and constants for the serial multiplier sequencing controller.
package mul_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // Two's-complement magnitude of a 32-bit value when neg is set; the most
    // negative value maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN_DEF-1:0] cond_abs(input logic [XLEN_DEF-1:0] v,
                                                     input logic                neg);
        logic [XLEN_DEF-1:0] r;
        if (neg) begin
            r = (~v) + {{(XLEN_DEF-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// One-bit-per-cycle shift-add datapath: accumulator, multiplicand,
// multiplier shift register and iteration count.
module mul_shift_add
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [XLEN-1:0]   mcand_i,
    input  logic [XLEN-1:0]   mplier_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              last_iter_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state: the multiplicand shifts left and the multiplier shifts right,
    // so mplier_q[0] is bit[count] and mcand_q is mcand << count.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            acc_d    = {(2*XLEN){1'b0}};
            mcand_d  = {(2*XLEN){1'b0}};
            mplier_d = {XLEN{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else if (load_i) begin
            acc_d    = {(2*XLEN){1'b0}};
            mcand_d  = {{XLEN{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            cnt_d    = {CNT_W{1'b0}};
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            if (last_iter_o) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= {(2*XLEN){1'b0}};
            mcand_q  <= {(2*XLEN){1'b0}};
            mplier_q <= {XLEN{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc_o       = acc_q;
    assign last_iter_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the EX-stage serial multiplier: handshake, sign
// conditioning, iteration control, sign fix-up, word select and flush.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    mul_state_e        state_q, state_d;
    mul_op_e           op_q, op_d;
    logic              neg_q, neg_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [TAG_W-1:0]  otag_q, otag_d;

    logic              accept_s;
    logic              sign_a_s, sign_b_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic              zero_s;
    logic [2*XLEN-1:0] acc_s, prod_s;
    logic [XLEN-1:0]   word_s;
    logic              last_iter_s;
    logic              sa_load_s, sa_step_s, sa_clear_s;

    assign in_ready = (state_q == IDLE) && !flush;
    assign accept_s = in_valid && in_ready;
    assign zero_s   = (in_a == {XLEN{1'b0}}) || (in_b == {XLEN{1'b0}});

    // Operand sign conditioning: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (mul_op_e'(in_op))
            MULH: begin
                sign_a_s = in_a[XLEN-1];
                sign_b_s = in_b[XLEN-1];
            end
            MULHSU: begin
                sign_a_s = in_a[XLEN-1];
                sign_b_s = 1'b0;
            end
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
        mag_a_s = cond_abs(in_a, sign_a_s);
        mag_b_s = cond_abs(in_b, sign_b_s);
    end

    // Sign fix-up of the unsigned magnitude product and low/high word select.
    always_comb begin
        if (neg_q) begin
            prod_s = (~acc_s) + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_s;
        end
        if (op_q == MUL) begin
            word_s = prod_s[XLEN-1:0];
        end else begin
            word_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // FSM next-state, datapath controls and result/tag capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_d      = neg_q;
        tag_d      = tag_q;
        res_d      = res_q;
        otag_d     = otag_q;
        sa_load_s  = 1'b0;
        sa_step_s  = 1'b0;
        sa_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d  = mul_op_e'(in_op);
                    neg_d = sign_a_s ^ sign_b_s;
                    tag_d = in_tag;
                    if (zero_s) begin
                        state_d = DONE;
                        res_d   = {XLEN{1'b0}};
                        otag_d  = in_tag;
                    end else begin
                        state_d   = CALC;
                        sa_load_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d    = IDLE;
                    sa_clear_s = 1'b1;
                end else begin
                    sa_step_s = 1'b1;
                    if (last_iter_s) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d    = IDLE;
                    sa_clear_s = 1'b1;
                end else begin
                    res_d   = word_s;
                    otag_d  = tag_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MUL;
            neg_q   <= 1'b0;
            tag_q   <= {TAG_W{1'b0}};
            res_q   <= {XLEN{1'b0}};
            otag_q  <= {TAG_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            otag_q  <= otag_d;
        end
    end

    mul_shift_add #(
        .XLEN (XLEN)
    ) u_shift_add (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (sa_clear_s),
        .load_i      (sa_load_s),
        .step_i      (sa_step_s),
        .mcand_i     (mag_a_s),
        .mplier_i    (mag_b_s),
        .acc_o       (acc_s),
        .last_iter_o (last_iter_s)
    );

    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_tag    = otag_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl against a plain-arithmetic RV32M model.
module tb_mul_seq_ctrl;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic check_val(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag_s, obs, exp);
        end
    endtask

    // RV32M reference: extend each operand per its signedness, multiply mod 2^64.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int hold);
        logic [31:0] exp_r;
        int          lat_exp;
        int          lat;
        bit          seen;
        exp_r   = ref_mul(op, a, b);
        lat_exp = (a == 32'd0 || b == 32'd0) ? 1 : 34;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = 1'b0;
        #1 check_val("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = 5'($urandom);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 60) begin
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                check_val("busy_in_flight", busy, 1'b1);
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            check_val("out_valid_timeout", out_valid, 1'b1);
            return;
        end
        check_val("latency", 64'(lat), 64'(lat_exp));
        check_val("busy_done", busy, 1'b1);
        check_val("result", out_result, exp_r);
        check_val("tag", out_tag, tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", out_valid, 1'b1);
            check_val("hold_result", out_result, exp_r);
            check_val("hold_tag", out_tag, tag);
            check_val("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_hs_valid", out_valid, 1'b0);
        check_val("post_hs_busy", busy, 1'b0);
        check_val("post_hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] corner [4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 5'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h7FFF_FFFF;

        repeat (3) @(negedge clk);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_result", out_result, 32'd0);
        check_val("rst_tag", out_tag, 5'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);

        // Directed cases from the corner list of the block.
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd17, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
        run_op(2'd0, 32'h0000_0000, 32'h1234_5678, 5'd6, 0);
        run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_0000, 5'd9, 2);
        run_op(2'd3, 32'h0000_1234, 32'h0000_5678, 5'd21, 10);

        // Flush mid-CALC with the request held valid.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_a     = 32'h1234_5678;
        in_b     = 32'h9ABC_DEF0;
        in_tag   = 5'd11;
        @(posedge clk);
        repeat (11) @(negedge clk);
        check_val("flush_pre_busy", busy, 1'b1);
        flush = 1'b1;
        #1 check_val("flush_in_ready_calc", in_ready, 1'b0);
        @(negedge clk);
        check_val("flush_out_valid", out_valid, 1'b0);
        check_val("flush_busy", busy, 1'b0);
        check_val("flush_in_ready_idle", in_ready, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1 check_val("flush_in_ready_after", in_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_val("flush_no_result", out_valid, 1'b0);
        end
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 5'd12, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 5'd13, 0);

        // Reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = 32'd123;
        in_b     = 32'd456;
        in_tag   = 5'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_result", out_result, 32'd0);
        check_val("mid_rst_tag", out_tag, 5'd0);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_in_ready", in_ready, 1'b1);
        run_op(2'd0, 32'd6, 32'd7, 5'd14, 0);

        // Randomized operations with occasional corner operands.
        for (int k = 0; k < 30; k++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            run_op(2'($urandom_range(0, 3)), ra, rb, 5'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
